sobel_edge_stage: RTL and testbench

- Streaming Sobel edge-magnitude stage. Sits directly downstream of the Gaussian smoothing convolution.
- Accepts smoothed grayscale pixels in raster order through a valid/ready handshake and buffers two image lines internally.
- Emits one edge pixel, computed as |Gx|+|Gy| and saturated, for every interior image position.
- Feeds the thresholding and output-writeback logic.

---
 rtl/sobel_edge_stage.sv | 155 +++++++++++++++
 tb/tb_sobel_edge_stage.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_edge_stage.sv
// ============================================================================
// Module   : sobel_edge_stage
// Brief    : Streaming 3x3 Sobel |Gx|+|Gy| stage with two internal line buffers.
//            Define SOBEL_THRESHOLD_EN to emit a binary edge map instead.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sobel_edge_stage #(
    parameter int COL_DEPTH    = 8,
    parameter int IMAGE_WIDTH  = 20,
    parameter int IMAGE_HEIGHT = 20,
    parameter int THRESHOLD    = 64
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            in_sof,
    input  logic [COL_DEPTH-1:0]            in_pixel,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [COL_DEPTH-1:0]            out_pixel,
    output logic [$clog2(IMAGE_WIDTH)-1:0]  out_x,
    output logic [$clog2(IMAGE_HEIGHT)-1:0] out_y,
    output logic                            out_eof
);

    localparam int XW = $clog2(IMAGE_WIDTH);
    localparam int YW = $clog2(IMAGE_HEIGHT);
    localparam int GW = COL_DEPTH + 3;

    localparam logic [XW-1:0] c_COL_LAST = XW'(IMAGE_WIDTH - 1);
    localparam logic [YW-1:0] c_ROW_LAST = YW'(IMAGE_HEIGHT - 1);
    localparam logic [GW-1:0] c_PIX_MAX  = GW'((1 << COL_DEPTH) - 1);

    logic [XW-1:0]        r_col;
    logic [YW-1:0]        r_row;
    logic [COL_DEPTH-1:0] r_lb0 [IMAGE_WIDTH];
    logic [COL_DEPTH-1:0] r_lb1 [IMAGE_WIDTH];
    logic [COL_DEPTH-1:0] r_win [3][3];

    logic                 r_out_valid;
    logic [COL_DEPTH-1:0] r_out_pixel;
    logic [XW-1:0]        r_out_x;
    logic [YW-1:0]        r_out_y;
    logic                 r_out_eof;

    logic                 w_xfer;
    logic                 w_gate;
    logic [XW-1:0]        w_col;
    logic [YW-1:0]        w_row;
    logic [XW-1:0]        w_col_nxt;
    logic [YW-1:0]        w_row_nxt;
    logic [COL_DEPTH-1:0] w_p [3][3];
    logic signed [GW-1:0] w_gx;
    logic signed [GW-1:0] w_gy;
    logic [GW-1:0]        w_ax;
    logic [GW-1:0]        w_ay;
    logic [GW-1:0]        w_mag;
    logic [COL_DEPTH-1:0] w_res;

    function automatic logic signed [GW-1:0] ext(input logic [COL_DEPTH-1:0] p);
        return signed'(GW'(p));
    endfunction

    assign in_ready = !r_out_valid || out_ready;
    assign w_xfer   = in_valid && in_ready;

    // in_sof forces the accepted beat to (0,0) whatever the counters hold
    assign w_col = in_sof ? '0 : r_col;
    assign w_row = in_sof ? '0 : r_row;

    assign w_col_nxt = (w_col == c_COL_LAST) ? '0 : w_col + 1'b1;
    assign w_row_nxt = (w_col != c_COL_LAST) ? w_row :
                       (w_row == c_ROW_LAST) ? '0 : w_row + 1'b1;

    assign w_gate = w_xfer && (w_row >= YW'(2)) && (w_col >= XW'(2));

    // Window as it stands after this beat: shifted left, new column on the right
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_p[i][0] = r_win[i][1];
            w_p[i][1] = r_win[i][2];
        end
        w_p[0][2] = r_lb1[w_col];
        w_p[1][2] = r_lb0[w_col];
        w_p[2][2] = in_pixel;
    end

    assign w_gx = (ext(w_p[0][2]) + (ext(w_p[1][2]) <<< 1) + ext(w_p[2][2]))
                - (ext(w_p[0][0]) + (ext(w_p[1][0]) <<< 1) + ext(w_p[2][0]));
    assign w_gy = (ext(w_p[2][0]) + (ext(w_p[2][1]) <<< 1) + ext(w_p[2][2]))
                - (ext(w_p[0][0]) + (ext(w_p[0][1]) <<< 1) + ext(w_p[0][2]));

    assign w_ax  = w_gx[GW-1] ? -w_gx : w_gx;
    assign w_ay  = w_gy[GW-1] ? -w_gy : w_gy;
    assign w_mag = w_ax + w_ay;

`ifdef SOBEL_THRESHOLD_EN
    localparam logic [GW-1:0] c_THRESH = GW'(THRESHOLD);
    assign w_res = (w_mag >= c_THRESH) ? '1 : '0;
`else
    assign w_res = (w_mag > c_PIX_MAX) ? '1 : w_mag[COL_DEPTH-1:0];
`endif

    // Line buffers carry no reset; stale rows are never gated into an output
    always_ff @(posedge clk) begin
        if (w_xfer) begin
            r_lb1[w_col] <= r_lb0[w_col];
            r_lb0[w_col] <= in_pixel;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_col       <= '0;
            r_row       <= '0;
            r_out_valid <= 1'b0;
            r_out_pixel <= '0;
            r_out_x     <= '0;
            r_out_y     <= '0;
            r_out_eof   <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    r_win[i][j] <= '0;
                end
            end
        end else begin
            if (w_xfer) begin
                r_col <= w_col_nxt;
                r_row <= w_row_nxt;
                r_win <= w_p;
            end
            if (w_gate) begin
                r_out_valid <= 1'b1;
                r_out_pixel <= w_res;
                r_out_x     <= w_col - 1'b1;
                r_out_y     <= w_row - 1'b1;
                r_out_eof   <= (w_row == c_ROW_LAST) && (w_col == c_COL_LAST);
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_pixel = r_out_pixel;
    assign out_x     = r_out_x;
    assign out_y     = r_out_y;
    assign out_eof   = r_out_eof;

endmodule

`default_nettype wire

// File: tb/tb_sobel_edge_stage.sv
// ============================================================================
// Module   : tb_sobel_edge_stage
// Brief    : Self-checking bench for sobel_edge_stage (frame table + corner cases).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sobel_edge_stage;

    localparam int CD  = 8;
    localparam int W   = 20;
    localparam int H   = 20;
    localparam int THR = 64;
`ifdef SOBEL_THRESHOLD_EN
    localparam int RAMP_EXP = (80 >= THR) ? 255 : 0;
`else
    localparam int RAMP_EXP = 80;
`endif

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_sof;
    logic [CD-1:0]          in_pixel;
    logic                   out_valid;
    logic                   out_ready;
    logic [CD-1:0]          out_pixel;
    logic [$clog2(W)-1:0]   out_x;
    logic [$clog2(H)-1:0]   out_y;
    logic                   out_eof;

    sobel_edge_stage #(
        .COL_DEPTH   (CD),
        .IMAGE_WIDTH (W),
        .IMAGE_HEIGHT(H),
        .THRESHOLD   (THR)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sof   (in_sof),
        .in_pixel (in_pixel),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pixel(out_pixel),
        .out_x    (out_x),
        .out_y    (out_y),
        .out_eof  (out_eof)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pix;
        int x;
        int y;
        int eof;
    } out_t;

    typedef struct {
        int pat;
        int duty;
        int probe_x;
        int probe_y;
        int exp_probe;
        int exp_count;
        int chk_lat;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   img [H][W];
    out_t exp_q [$];
    int   duty = 100;
    int   cyc = 0;
    int   n_out = 0;
    int   first_t = -1;
    int   xfer_t = -2;
    int   probe_x = -1;
    int   probe_y = -1;
    int   probe_val = -1;
    int   abort = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: direct 3x3 kernel convolution over the stored frame
    function automatic int ref_pix(input int y, input int x);
        int kx [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
        int ky [9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};
        int gx = 0;
        int gy = 0;
        int mag;
        for (int dy = 0; dy < 3; dy++) begin
            for (int dx = 0; dx < 3; dx++) begin
                gx += kx[dy*3+dx] * img[y-1+dy][x-1+dx];
                gy += ky[dy*3+dx] * img[y-1+dy][x-1+dx];
            end
        end
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef SOBEL_THRESHOLD_EN
        return (mag >= THR) ? 255 : 0;
`else
        return (mag > 255) ? 255 : mag;
`endif
    endfunction

    // An interior centre (y,x) is produced once raster pixel (y+1,x+1) is accepted
    task automatic push_expected(input int n_pix);
        for (int y = 1; y < H-1; y++) begin
            for (int x = 1; x < W-1; x++) begin
                if ((y+1)*W + (x+1) < n_pix)
                    exp_q.push_back('{ref_pix(y, x), x, y, (y == H-2 && x == W-2) ? 1 : 0});
            end
        end
    endtask

    task automatic fill(input int pat);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                case (pat)
                    0:       img[y][x] = 100;
                    1:       img[y][x] = (x < 10) ? 0 : 200;
                    2:       img[y][x] = x * 10;
                    3:       img[y][x] = int'($urandom_range(255));
                    default: img[y][x] = ($urandom_range(1) != 0) ? 255 : 0;
                endcase
            end
        end
    endtask

    task automatic send(input int n, input int sof);
        int got;
        for (int i = 0; i < n && abort == 0; i++) begin
            in_valid = 1'b1;
            in_sof   = (sof != 0 && i == 0);
            in_pixel = CD'(img[i / W][i % W]);
            got = 0;
            for (int t = 0; t < 100 && got == 0; t++) begin
                @(negedge clk);
                got = int'(in_ready);
                @(posedge clk);
                #1;
            end
            if (got == 0) begin
                check("xfer_timeout", got, 1);
                abort = 1;
            end
            if (i == 2*W + 2) xfer_t = cyc;
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clk);
        check("drain", exp_q.size(), 0);
        @(negedge clk);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = (int'($urandom_range(99)) < duty);
        end
    end

    // Output monitor: scoreboard, handshake rule and hold-while-stalled checks
    initial begin
        out_t e;
        int   stalled = 0;
        int   held = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                stalled = 0;
            end else begin
                check("in_ready_rule", int'(in_ready), int'(!out_valid || out_ready));
                if (stalled != 0) begin
                    check("hold_valid", int'(out_valid), 1);
                    check("hold_data", int'({out_pixel, out_x, out_y, out_eof}), held);
                end
                if (out_valid && first_t < 0) first_t = cyc;
                if (out_valid && out_ready) begin
                    n_out++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_out", int'(out_valid), 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_pixel", int'(out_pixel), e.pix);
                        check("out_x", int'(out_x), e.x);
                        check("out_y", int'(out_y), e.y);
                        check("out_eof", int'(out_eof), e.eof);
                    end
                    if (int'(out_x) == probe_x && int'(out_y) == probe_y)
                        probe_val = int'(out_pixel);
                end
                stalled = (out_valid && !out_ready) ? 1 : 0;
                held    = int'({out_pixel, out_x, out_y, out_eof});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv [7];
        tv[0] = '{0, 100, 18, 18, 0,        324, 1};
        tv[1] = '{1, 100,  9,  4, 255,      324, 0};
        tv[2] = '{1,  50, 10,  7, 255,      324, 0};
        tv[3] = '{2, 100,  7,  7, RAMP_EXP, 324, 0};
        tv[4] = '{2,  50,  1,  1, RAMP_EXP, 324, 0};
        tv[5] = '{3,  50,  3,  3, -1,       324, 0};
        tv[6] = '{4,  50,  5,  5, -1,       324, 0};

        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_pixel = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_pixel", int'(out_pixel), 0);
        check("rst_out_x", int'(out_x), 0);
        check("rst_out_y", int'(out_y), 0);
        check("rst_out_eof", int'(out_eof), 0);
        check("rst_in_ready", int'(in_ready), 1);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < 7 && abort == 0; v++) begin
            fill(tv[v].pat);
            duty      = tv[v].duty;
            probe_x   = tv[v].probe_x;
            probe_y   = tv[v].probe_y;
            probe_val = -1;
            n_out     = 0;
            first_t   = -1;
            xfer_t    = -2;
            push_expected(W*H);
            send(W*H, 1);
            drain();
            check("frame_count", n_out, tv[v].exp_count);
            if (tv[v].exp_probe >= 0) check("probe", probe_val, tv[v].exp_probe);
            if (tv[v].chk_lat != 0) check("first_latency", first_t, xfer_t);
        end

        // Reset after 150 transfers: the output loaded on the last one is dropped
        fill(3);
        duty = 100;
        repeat (3) @(posedge clk);
        #1;
        push_expected(149);
        send(150, 1);
        reset_n = 1'b0;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        check("midrst_drained", exp_q.size(), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        fill(4);
        n_out = 0;
        push_expected(W*H);
        send(W*H, 1);
        drain();
        check("post_rst_count", n_out, 324);

        // in_sof after 75 pixels: 31 outputs of the abandoned frame, then 324
        fill(3);
        duty  = 50;
        n_out = 0;
        push_expected(75);
        send(75, 1);
        fill(4);
        push_expected(W*H);
        send(W*H, 1);
        drain();
        check("resync_count", n_out, 31 + 324);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
